priority_req_encoder: RTL and testbench
=======================================

PRIORITY_REQ_ENCODER -- requirements
Module: priority_req_encoder

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the number of request channels (legal range 2..32).
REQ-002 The block SHALL have parameter RR_MODE, default 0, meaning 0 = fixed priority and 1 = round-robin.
REQ-003 The block SHALL derive localparam IW = clog2(N) as the index width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port req, input, N bits: request lines, sampled each clock.
REQ-007 The block SHALL have port mask, input, N bits: a 1 blocks that channel from selection.
REQ-008 The block SHALL have port clr_all, input, 1 bit: synchronous clear of all pending state.
REQ-009 The block SHALL have port out_valid, output, 1 bit: a grant is presented.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the grant.
REQ-011 The block SHALL have port out_idx, output, IW bits: index of the granted channel.
REQ-012 The block SHALL have port pending, output, N bits: the sticky pending register.

Function
REQ-013 Each pending[i] SHALL set at a clock edge where req[i]=1, and SHALL remain set until cleared per REQ-019 or REQ-020.
REQ-014 The eligible set SHALL be pending & ~mask.
REQ-015 The FSM SHALL have two states, IDLE (out_valid=0) and GRANT (out_valid=1), with the following transitions:
- IDLE -> GRANT when the eligible set is nonzero; out_idx is loaded with the selected index on the same edge.
- GRANT -> IDLE on an edge where out_valid & out_ready.
REQ-016 When RR_MODE=0, selection SHALL pick the highest eligible index (bit N-1 has highest priority).
REQ-017 When RR_MODE=1, selection SHALL search ascending from last_grant+1, wrapping at N-1 to 0; last_grant updates on each handshake and resets to N-1, so the first search starts at 0.
REQ-018 Latency SHALL be as follows:
- req[i] high at edge k sets pending at k, giving out_valid at edge k+1 if the block is idle and the channel is selected.
- Maximum throughput is one grant per 2 cycles.
REQ-019 On handshake, pending[out_idx] SHALL clear, except that it stays set if req[out_idx]=1 on the same edge (set wins over clear).
REQ-020 clr_all=1 SHALL, on that edge, clear pending to 0, force IDLE, and drop out_valid; it overrides a same-edge req set and a same-edge handshake; last_grant is unchanged.
REQ-021 While in GRANT, out_idx SHALL hold stable until the handshake, regardless of changes to req, mask or higher-priority arrivals; no grant is ever revoked by mask.
REQ-022 While out_valid=0, out_idx SHALL hold its last value.
REQ-023 If the eligible set is zero, the block SHALL remain in IDLE; bits pending under mask are retained and become eligible the cycle after mask drops.
REQ-024 out_valid and out_idx SHALL be driven directly from registers, with no combinational path from req, mask or out_ready.

Reset
REQ-025 While rst=1, the block SHALL hold pending=0, out_valid=0, out_idx=0, last_grant=N-1 and state IDLE, asynchronously and irrespective of clk.
REQ-026 After rst deasserts, the first selection SHALL occur no earlier than the first edge with rst low.
REQ-027 rst asserted mid-GRANT SHALL drop out_valid immediately, without waiting for a clock edge.

Verification
REQ-028 The bench SHALL cover the scenarios below.
- Fixed priority: N=8, RR_MODE=0, one-cycle pulse on req=0b00100110, out_ready=1 -> grants 5, 2, 1 in order, each 2 cycles apart; pending reaches 0.
- Round-robin: N=4, RR_MODE=1, req held at 0b1111 -> grants cycle 0, 1, 2, 3, 0; pending stays 0b1111 because set wins (REQ-019).
- Mask/hold: in GRANT idx 3 with out_ready=0, set mask[3]=1 and pulse req[7] -> out_idx stays 3 until out_ready=1, then idx 7 is granted.
- clr_all collision: clr_all=1 on the same edge as a handshake and req=0b0001 -> pending=0, out_valid=0 next cycle, and no further grant.
- Async reset: assert rst between clock edges while in GRANT -> out_valid goes 0 before the next clk edge; pending=0 and out_idx=0.

Source files
------------

// File: rtl/priority_req_encoder.sv
`default_nettype none
// ============================================================================
// priority_req_encoder : sticky request capture with a registered
// fixed-priority or round-robin grant and a valid/ready handshake.
// Rev 1.0
// ============================================================================
module priority_req_encoder #(
  parameter int N       = 8,
  parameter int RR_MODE = 0,
  localparam int IW     = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic          clr_all,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic [N-1:0]  pending
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]    r_state;
  logic [N-1:0]  r_pending;
  logic [IW-1:0] r_idx;
  logic [N-1:0]  w_elig;
  logic [N-1:0]  w_hs_clr;
  logic [IW-1:0] w_sel;
  logic          w_hs;

  assign w_elig   = r_pending & ~mask;
  assign w_hs     = (r_state == S_GRANT) && out_ready;
  assign w_hs_clr = w_hs ? ({{(N-1){1'b0}}, 1'b1} << r_idx) : '0;

  if (RR_MODE == 0) begin : g_fixed
    // Ascending scan: the last hit is the highest eligible index.
    always_comb begin
      w_sel = '0;
      for (int i = 0; i < N; i++) begin
        if (w_elig[i]) w_sel = IW'(i);
      end
    end
  end else begin : g_rr
    logic [IW-1:0] r_last;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_last <= IW'(N - 1);
      end else if (w_hs && !clr_all) begin
        r_last <= r_idx;
      end
    end

    // Descending offset scan so the nearest channel after r_last wins.
    always_comb begin
      w_sel = '0;
      for (int k = N - 1; k >= 0; k--) begin
        if (w_elig[(int'(r_last) + 1 + k) % N]) w_sel = IW'((int'(r_last) + 1 + k) % N);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_state   <= S_IDLE;
      r_idx     <= '0;
    end else if (clr_all) begin
      r_pending <= '0;
      r_state   <= S_IDLE;
    end else begin
      r_pending <= (r_pending & ~w_hs_clr) | req;
      case (r_state)
        S_IDLE: begin
          if (|w_elig) begin
            r_state <= S_GRANT;
            r_idx   <= w_sel;
          end
        end
        S_GRANT: begin
          if (out_ready) r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_valid = (r_state == S_GRANT);
  assign out_idx   = r_idx;
  assign pending   = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_priority_req_encoder.sv
`default_nettype none
// Testbench for priority_req_encoder: directed vectors on a fixed-priority
// N=8 instance and a round-robin N=4 instance.
module tb_priority_req_encoder;

  logic       clk;
  logic       rst;
  int         n_checks;
  int         n_fail;

  // Fixed-priority instance
  logic [7:0] a_req, a_mask, a_pending;
  logic       a_clr, a_valid, a_ready;
  logic [2:0] a_idx;

  // Round-robin instance
  logic [3:0] b_req, b_mask, b_pending;
  logic       b_clr, b_valid, b_ready;
  logic [1:0] b_idx;

  priority_req_encoder #(.N(8), .RR_MODE(0)) u_fix (
    .clk(clk), .rst(rst), .req(a_req), .mask(a_mask), .clr_all(a_clr),
    .out_valid(a_valid), .out_ready(a_ready), .out_idx(a_idx), .pending(a_pending)
  );

  priority_req_encoder #(.N(4), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .req(b_req), .mask(b_mask), .clr_all(b_clr),
    .out_valid(b_valid), .out_ready(b_ready), .out_idx(b_idx), .pending(b_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_rr [5];
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    a_req = '0; a_mask = '0; a_clr = 1'b0; a_ready = 1'b1;
    b_req = '0; b_mask = '0; b_clr = 1'b0; b_ready = 1'b1;
    tick();
    tick();
    check("reset_valid", a_valid, 0);
    check("reset_idx", a_idx, 0);
    check("reset_pending", a_pending, 0);
    check("reset_rr_valid", b_valid, 0);
    rst = 1'b0;

    // Fixed priority: pulse 0b00100110, grants 5, 2, 1 two cycles apart.
    a_req = 8'h26;
    tick();
    check("fix_pend_set", a_pending, 8'h26);
    check("fix_not_yet", a_valid, 0);
    a_req = 8'h00;
    tick(); check("fix_g5_v", a_valid, 1); check("fix_g5_i", a_idx, 5);
    tick(); check("fix_hs5_v", a_valid, 0); check("fix_hs5_p", a_pending, 8'h06);
    tick(); check("fix_g2_v", a_valid, 1); check("fix_g2_i", a_idx, 2);
    tick(); check("fix_hs2_p", a_pending, 8'h02);
    tick(); check("fix_g1_v", a_valid, 1); check("fix_g1_i", a_idx, 1);
    tick(); check("fix_done_p", a_pending, 8'h00); check("fix_done_v", a_valid, 0);
    check("fix_idx_hold", a_idx, 1);
    tick(); check("fix_idle_v", a_valid, 0);

    // Mask/hold: grant 3 stalled, mask it and raise 7; 3 stays until accepted.
    a_ready = 1'b0;
    a_req = 8'h08;
    tick();
    a_req = 8'h00;
    tick(); check("hold_g3_v", a_valid, 1); check("hold_g3_i", a_idx, 3);
    a_mask = 8'h08;
    a_req  = 8'h80;
    tick(); check("hold_i_a", a_idx, 3); check("hold_p", a_pending, 8'h88);
    a_req = 8'h00;
    tick(); check("hold_i_b", a_idx, 3); check("hold_v_b", a_valid, 1);
    a_ready = 1'b1;
    tick(); check("hold_hs_v", a_valid, 0); check("hold_hs_p", a_pending, 8'h80);
    tick(); check("hold_g7_v", a_valid, 1); check("hold_g7_i", a_idx, 7);
    tick(); check("hold_end_p", a_pending, 8'h00);
    a_mask = 8'h00;

    // Masked pending bit is retained and granted once the mask drops.
    a_mask = 8'h01;
    a_req  = 8'h01;
    tick();
    a_req = 8'h00;
    tick(); check("msk_idle_a", a_valid, 0);
    tick(); check("msk_idle_b", a_valid, 0); check("msk_keep_p", a_pending, 8'h01);
    a_mask = 8'h00;
    tick(); check("msk_g0_v", a_valid, 1); check("msk_g0_i", a_idx, 0);
    tick(); check("msk_end_p", a_pending, 8'h00);

    // clr_all on the handshake edge overrides the handshake and a req set.
    a_ready = 1'b0;
    a_req = 8'h04;
    tick();
    a_req = 8'h00;
    tick(); check("clr_g2_v", a_valid, 1); check("clr_g2_i", a_idx, 2);
    a_ready = 1'b1;
    a_clr   = 1'b1;
    a_req   = 8'h01;
    tick(); check("clr_v", a_valid, 0); check("clr_p", a_pending, 8'h00);
    a_clr = 1'b0;
    a_req = 8'h00;
    tick(); check("clr_no_grant_a", a_valid, 0);
    tick(); check("clr_no_grant_b", a_valid, 0); check("clr_p2", a_pending, 8'h00);

    // Asynchronous reset in the middle of a grant.
    a_ready = 1'b0;
    a_req = 8'h40;
    tick();
    a_req = 8'h00;
    tick(); check("ar_g6_v", a_valid, 1); check("ar_g6_i", a_idx, 6);
    #2;
    rst = 1'b1;
    #1;
    check("ar_v", a_valid, 0);
    check("ar_p", a_pending, 8'h00);
    check("ar_i", a_idx, 0);
    tick();
    rst = 1'b0;
    a_ready = 1'b1;

    // Round-robin: req held at 0b1111, grants 0,1,2,3,0 and pending stays full.
    exp_rr = '{0, 1, 2, 3, 0};
    b_req = 4'hF;
    tick();
    check("rr_pend_set", b_pending, 4'hF);
    check("rr_not_yet", b_valid, 0);
    for (int g = 0; g < 5; g++) begin
      tick();
      check("rr_grant_v", b_valid, 1);
      check($sformatf("rr_grant_i%0d", g), b_idx, exp_rr[g]);
      tick();
      check("rr_hs_v", b_valid, 0);
      check("rr_hs_p", b_pending, 4'hF);
    end
    b_req = 4'h0;
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    check("rr_clr_p", b_pending, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
